// File: rtl/poly_pwm_mixer_if.sv
// -----------------------------------------------------------------------------
// poly_pwm_mixer_if
// Bundles the mixer's control, voice and audio-output signals so the mixer
// and its upstream (waveshapers / bench) connect through one port.
//
// Signals (directions as seen by the mixer, i.e. the slave modport):
//   en            in   block enable; low freezes the block
//   avg_mode_i    in   0 = saturating sum, 1 = average
//   voice_on_i    in   per-voice gate bits
//   sample_i      in   packed unsigned samples, voice v at [v*SAMPLE_W +: SAMPLE_W]
//   sample_req_o  out  one-cycle pulse at period start
//   mix_o         out  latest completed mix
//   clip_o        out  latest sum-mode mix saturated
//   active_o      out  number of gated voices in the latest mix
//   pwm_o         out  PWM audio output
// -----------------------------------------------------------------------------
interface poly_pwm_mixer_if #(
  parameter int VOICES   = 4,
  parameter int SAMPLE_W = 8
);
  localparam int ACT_W = $clog2(VOICES + 1);

  logic                         en;
  logic                         avg_mode_i;
  logic [VOICES-1:0]            voice_on_i;
  logic [VOICES*SAMPLE_W-1:0]   sample_i;
  logic                         sample_req_o;
  logic [SAMPLE_W-1:0]          mix_o;
  logic                         clip_o;
  logic [ACT_W-1:0]             active_o;
  logic                         pwm_o;

  // Upstream side: drives voices and control, observes the audio stage.
  modport master (
    output en, avg_mode_i, voice_on_i, sample_i,
    input  sample_req_o, mix_o, clip_o, active_o, pwm_o
  );

  // Mixer side.
  modport slave (
    input  en, avg_mode_i, voice_on_i, sample_i,
    output sample_req_o, mix_o, clip_o, active_o, pwm_o
  );
endinterface

// File: rtl/poly_pwm_mixer.sv
// -----------------------------------------------------------------------------
// poly_pwm_mixer
// Multi-voice mixer feeding a fixed-period PWM output. A free-running period
// counter drives everything: at cnt=0 the accumulator clears and a sample
// request goes upstream, at cnt=1..VOICES one voice per cycle is added (gated
// by its note-on bit), at cnt=VOICES+1 the mix is committed (saturated or
// averaged), and at the MAX->0 wrap the committed mix becomes the PWM duty
// for the following period.
//
// Ports:
//   clk    in  system clock
//   n_rst  in  synchronous active-low reset (applies regardless of en)
//   bus    poly_pwm_mixer_if.slave, see the interface for signal meanings
// -----------------------------------------------------------------------------
module poly_pwm_mixer #(
  parameter int VOICES   = 4,
  parameter int SAMPLE_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  poly_pwm_mixer_if.slave  bus
);

  localparam int LOG2V = $clog2(VOICES);
  localparam int ACC_W = SAMPLE_W + LOG2V;
  localparam int ACT_W = $clog2(VOICES + 1);

  localparam logic [SAMPLE_W-1:0] CNT_ZERO  = {SAMPLE_W{1'b0}};
  localparam logic [SAMPLE_W-1:0] CNT_MAX   = {SAMPLE_W{1'b1}};
  localparam logic [SAMPLE_W-1:0] CNT_LAST  = SAMPLE_W'(VOICES);
  localparam logic [ACC_W-1:0]    ACC_MAX   = ACC_W'({SAMPLE_W{1'b1}});
  localparam logic [ACC_W-1:0]    ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [ACT_W-1:0]    ACT_ZERO  = {ACT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Clamp the wide accumulator into the output range.
  function automatic logic [SAMPLE_W-1:0] sat_mix(input logic [ACC_W-1:0] a);
    return (a > ACC_MAX) ? {SAMPLE_W{1'b1}} : a[SAMPLE_W-1:0];
  endfunction

  state_e               state_q, state_d;
  logic [SAMPLE_W-1:0]  cnt_q, cnt_d;
  logic                 wrap_s;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACT_W-1:0]     act_acc_q, act_acc_d;
  logic [SAMPLE_W-1:0]  duty_q, duty_d;
  logic                 sreq_q, sreq_d;
  logic [SAMPLE_W-1:0]  mix_q, mix_d;
  logic                 clip_q, clip_d;
  logic [ACT_W-1:0]     active_q, active_d;
  logic                 pwm_q, pwm_d;

  logic [SAMPLE_W-1:0]  voice_idx_s;
  logic [SAMPLE_W-1:0]  voice_smp_s;
  logic                 voice_gate_s;

  // Period counter: advances only while enabled, wraps naturally at MAX.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_s = 1'b0;
    if (bus.en) begin
      cnt_d  = cnt_q + SAMPLE_W'(1);
      wrap_s = (cnt_q == CNT_MAX);
    end else begin
      cnt_d  = cnt_q;
      wrap_s = 1'b0;
    end
  end

  // Mix FSM next state; it only moves on enabled cycles so a freeze holds it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && (cnt_q == CNT_ZERO)) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (bus.en && (cnt_q == CNT_LAST)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (bus.en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the voice for this accumulate cycle (cnt=k adds voice k-1) and gate it.
  always_comb begin
    voice_idx_s  = cnt_q - SAMPLE_W'(1);
    voice_smp_s  = {SAMPLE_W{1'b0}};
    voice_gate_s = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      voice_smp_s  = voice_smp_s
                   | ({SAMPLE_W{(voice_idx_s == SAMPLE_W'(v)) & bus.voice_on_i[v]}}
                      & bus.sample_i[v*SAMPLE_W +: SAMPLE_W]);
      voice_gate_s = voice_gate_s
                   | ((voice_idx_s == SAMPLE_W'(v)) & bus.voice_on_i[v]);
    end
  end

  // Accumulator and running gate count: cleared at period start, summed in ACCUM.
  always_comb begin
    acc_d     = acc_q;
    act_acc_d = act_acc_q;
    if (!bus.en) begin
      acc_d     = acc_q;
      act_acc_d = act_acc_q;
    end else if (state_q == ST_ACCUM) begin
      acc_d     = acc_q + ACC_W'(voice_smp_s);
      act_acc_d = act_acc_q + ACT_W'(voice_gate_s);
    end else if (cnt_q == CNT_ZERO) begin
      acc_d     = ACC_ZERO;
      act_acc_d = ACT_ZERO;
    end else begin
      acc_d     = acc_q;
      act_acc_d = act_acc_q;
    end
  end

  // Commit the finished mix in DONE; avg_mode_i is only looked at here.
  always_comb begin
    mix_d    = mix_q;
    clip_d   = clip_q;
    active_d = active_q;
    if (bus.en && (state_q == ST_DONE)) begin
      active_d = act_acc_q;
      if (bus.avg_mode_i) begin
        // Averaging divides by VOICES, which is a power of two.
        mix_d  = acc_q[LOG2V +: SAMPLE_W];
        clip_d = 1'b0;
      end else begin
        mix_d  = sat_mix(acc_q);
        clip_d = (acc_q > ACC_MAX);
      end
    end else begin
      mix_d    = mix_q;
      clip_d   = clip_q;
      active_d = active_q;
    end
  end

  // Duty reload at the wrap, period-start request and PWM compare.
  always_comb begin
    duty_d = duty_q;
    if (wrap_s) begin
      duty_d = mix_q;
    end else begin
      duty_d = duty_q;
    end
    sreq_d = bus.en & (cnt_q == CNT_ZERO);
    // Compare the next counter/duty pair so pwm_o lines up with the registered cnt.
    pwm_d  = bus.en & (cnt_d < duty_d);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      acc_q     <= ACC_ZERO;
      act_acc_q <= ACT_ZERO;
      duty_q    <= CNT_ZERO;
      sreq_q    <= 1'b0;
      mix_q     <= CNT_ZERO;
      clip_q    <= 1'b0;
      active_q  <= ACT_ZERO;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      act_acc_q <= act_acc_d;
      duty_q    <= duty_d;
      sreq_q    <= sreq_d;
      mix_q     <= mix_d;
      clip_q    <= clip_d;
      active_q  <= active_d;
      pwm_q     <= pwm_d;
    end
  end

  assign bus.sample_req_o = sreq_q;
  assign bus.mix_o        = mix_q;
  assign bus.clip_o       = clip_q;
  assign bus.active_o     = active_q;
  assign bus.pwm_o        = pwm_q;

endmodule

// File: tb/tb_poly_pwm_mixer.sv
// -----------------------------------------------------------------------------
// tb_poly_pwm_mixer
// Directed + randomized bench for poly_pwm_mixer (VOICES=4, SAMPLE_W=8).
// A reference model steps once per clock edge: it records each voice as seen
// on its accumulate cycle, forms the mix as a plain arithmetic sum at commit,
// and loads the duty at the wrap. Every cycle all outputs are compared, and
// the directed scenarios add explicit period-level checks.
// -----------------------------------------------------------------------------
module tb_poly_pwm_mixer;
  localparam int V   = 4;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic clk;
  logic n_rst;

  poly_pwm_mixer_if #(.VOICES(V), .SAMPLE_W(W)) bus ();

  poly_pwm_mixer #(.VOICES(V), .SAMPLE_W(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_cnt = 0, m_duty = 0, m_mix = 0, m_active = 0;
  bit m_clip = 1'b0, m_sreq = 1'b0, m_pwm = 1'b0;
  int cap   [V];
  int cap_on[V];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int sum, act;
    if (!n_rst) begin
      m_cnt = 0; m_duty = 0; m_mix = 0; m_active = 0;
      m_clip = 1'b0; m_sreq = 1'b0; m_pwm = 1'b0;
    end else if (bus.en) begin
      m_sreq = (m_cnt == 0);
      if (m_cnt >= 1 && m_cnt <= V) begin
        cap_on[m_cnt-1] = int'(bus.voice_on_i[m_cnt-1]);
        cap[m_cnt-1]    = bus.voice_on_i[m_cnt-1] ? int'(bus.sample_i[(m_cnt-1)*W +: W]) : 0;
      end
      if (m_cnt == V + 1) begin
        sum = 0; act = 0;
        for (int v = 0; v < V; v++) begin
          sum += cap[v];
          act += cap_on[v];
        end
        m_active = act;
        if (bus.avg_mode_i) begin
          m_mix  = sum / V;
          m_clip = 1'b0;
        end else begin
          m_mix  = (sum > MAX) ? MAX : sum;
          m_clip = (sum > MAX);
        end
      end
      if (m_cnt == MAX) m_duty = m_mix;
      m_cnt = (m_cnt + 1) % (MAX + 1);
      m_pwm = (m_cnt < m_duty);
    end else begin
      m_sreq = 1'b0;
      m_pwm  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("sample_req", 32'(bus.sample_req_o), 32'(m_sreq));
    check("mix",        32'(bus.mix_o),        32'(m_mix));
    check("clip",       32'(bus.clip_o),       32'(m_clip));
    check("active",     32'(bus.active_o),     32'(m_active));
    check("pwm",        32'(bus.pwm_o),        32'(m_pwm));
  endtask

  task automatic run_until_cnt(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target) begin
      tick();
      guard++;
      if (guard > 600) begin
        n_checks++;
        n_fail++;
        $error("FAIL run_bound: waited %0d cycles for cnt %0d", guard, target);
        break;
      end
    end
  endtask

  // Measures one period starting from the current cnt=0 cycle.
  task automatic count_period(output int highs, output int reqs, output int len);
    highs = int'(bus.pwm_o);
    reqs  = int'(bus.sample_req_o);
    len   = 1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (m_cnt == 0) break;
      highs += int'(bus.pwm_o);
      reqs  += int'(bus.sample_req_o);
      len++;
    end
  endtask

  task automatic set_all_samples(input int val);
    for (int v = 0; v < V; v++) bus.sample_i[v*W +: W] = W'(val);
  endtask

  task automatic randomize_inputs();
    bus.voice_on_i = V'($urandom);
    bus.avg_mode_i = 1'($urandom);
    for (int v = 0; v < V; v++) bus.sample_i[v*W +: W] = W'($urandom);
  endtask

  int highs, reqs, len;

  initial begin
    for (int v = 0; v < V; v++) begin cap[v] = 0; cap_on[v] = 0; end
    n_rst  = 1'b0;
    bus.en = 1'b1;
    randomize_inputs();

    // Reset held for 3 cycles with random inputs: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      randomize_inputs();
    end

    // Sum with saturation: 4 x 100 = 400 -> 255, clip.
    bus.voice_on_i = 4'hF;
    bus.avg_mode_i = 1'b0;
    set_all_samples(100);
    n_rst = 1'b1;
    tick();
    check("first_req", 32'(bus.sample_req_o), 32'd1);
    run_until_cnt(V + 2);
    check("sat_mix",    32'(bus.mix_o),    32'd255);
    check("sat_clip",   32'(bus.clip_o),   32'd1);
    check("sat_active", 32'(bus.active_o), 32'd4);
    run_until_cnt(0);
    count_period(highs, reqs, len);
    check("sat_pwm_highs", 32'(highs), 32'd255);
    check("sat_reqs",      32'(reqs),  32'd1);
    check("sat_len",       32'(len),   32'd256);

    // Average mode: 400 / 4 = 100.
    bus.avg_mode_i = 1'b1;
    run_until_cnt(V + 2);
    check("avg_mix",  32'(bus.mix_o),  32'd100);
    check("avg_clip", 32'(bus.clip_o), 32'd0);
    run_until_cnt(0);
    count_period(highs, reqs, len);
    check("avg_pwm_highs", 32'(highs), 32'd100);

    // Gating: only voice 1 on (200), others 255 but gated off.
    bus.avg_mode_i = 1'b0;
    bus.voice_on_i = 4'b0010;
    set_all_samples(255);
    bus.sample_i[1*W +: W] = 8'd200;
    run_until_cnt(V + 2);
    check("gate_mix",    32'(bus.mix_o),    32'd200);
    check("gate_clip",   32'(bus.clip_o),   32'd0);
    check("gate_active", 32'(bus.active_o), 32'd1);
    bus.voice_on_i = 4'b0000;
    run_until_cnt(0);
    run_until_cnt(V + 2);
    check("off_mix",    32'(bus.mix_o),    32'd0);
    check("off_active", 32'(bus.active_o), 32'd0);
    run_until_cnt(0);
    count_period(highs, reqs, len);
    check("off_pwm_highs", 32'(highs), 32'd0);

    // Random inputs changing every cycle, including during ACCUM.
    for (int i = 0; i < 3 * (MAX + 1); i++) begin
      randomize_inputs();
      tick();
    end

    // Enable freeze: 4 x 30 = 120 duty, en dropped at cnt=50 for 20 cycles.
    bus.voice_on_i = 4'hF;
    bus.avg_mode_i = 1'b0;
    set_all_samples(30);
    run_until_cnt(0);
    run_until_cnt(10);
    run_until_cnt(0);
    highs = int'(bus.pwm_o);
    reqs  = int'(bus.sample_req_o);
    len   = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      highs += int'(bus.pwm_o);
      reqs  += int'(bus.sample_req_o);
      len++;
    end
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("freeze_pwm_low", 32'(bus.pwm_o),        32'd0);
      check("freeze_no_req",  32'(bus.sample_req_o), 32'd0);
      reqs += int'(bus.sample_req_o);
      len++;
    end
    bus.en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (m_cnt == 0) break;
      highs += int'(bus.pwm_o);
      reqs  += int'(bus.sample_req_o);
      len++;
    end
    check("freeze_len",   32'(len),   32'd276);
    check("freeze_reqs",  32'(reqs),  32'd1);
    check("freeze_highs", 32'(highs), 32'd120);

    // Mid-period reset during ACCUM: partial sum discarded, next period duty 0.
    bus.voice_on_i = 4'hF;
    for (int v = 0; v < V; v++) bus.sample_i[v*W +: W] = W'($urandom_range(255, 1));
    run_until_cnt(3);
    n_rst = 1'b0;
    tick();
    check("rst_mix",  32'(bus.mix_o),  32'd0);
    check("rst_clip", 32'(bus.clip_o), 32'd0);
    n_rst = 1'b1;
    count_period(highs, reqs, len);
    check("rst_pwm_highs", 32'(highs), 32'd0);
    check("rst_reqs",      32'(reqs),  32'd1);
    check("rst_len",       32'(len),   32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
